// File: rtl/muldiv_sequencer.sv
// ============================================================================
// Module   : muldiv_sequencer
// Purpose  : Iterative RV32M multiply/divide unit (32-step shift-add /
//            restoring shift-subtract) with flush and fetch-stall control.
//            Optional macro MULDIV_EARLY_OUT_EN: divide-by-zero and signed
//            overflow finish straight from IDLE.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        flush,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        sa_q, sa_d;
    logic        sb_q, sb_d;
    logic [63:0] prod_q, prod_d;
    logic [31:0] result_q, result_d;

    // Operand signedness and magnitudes taken straight from the request
    logic        w_sgn_a, w_sgn_b, w_sa, w_sb;
    logic [31:0] w_a_mag, w_b_mag;

    assign w_sgn_a = (funct3 == 3'b001) | (funct3 == 3'b010) | (funct3[2] & ~funct3[0]);
    assign w_sgn_b = (funct3 == 3'b001) | (funct3[2] & ~funct3[0]);
    assign w_sa    = w_sgn_a & rs1[31];
    assign w_sb    = w_sgn_b & rs2[31];
    assign w_a_mag = w_sa ? -rs1 : rs1;
    assign w_b_mag = w_sb ? -rs2 : rs2;

`ifdef MULDIV_EARLY_OUT_EN
    logic        w_in_dz, w_in_ovf, w_early;
    logic [31:0] w_early_res;

    assign w_in_dz     = (rs2 == 32'd0);
    assign w_in_ovf    = funct3[2] & ~funct3[0] & (rs1 == 32'h8000_0000) & (rs2 == 32'hFFFF_FFFF);
    assign w_early     = funct3[2] & (w_in_dz | w_in_ovf);
    assign w_early_res = funct3[1] ? (w_in_dz ? rs1 : 32'd0)
                                   : (w_in_dz ? 32'hFFFF_FFFF : 32'h8000_0000);
`endif

    // One iteration step; multiply consumes the multiplier LSB-first from prod_q[31:0]
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;
    logic [32:0] w_rem_sh;
    logic        w_ge;
    logic [31:0] w_diff;
    logic [63:0] w_div_next;

    assign w_mul_sum  = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, a_q} : 33'd0);
    assign w_mul_next = {w_mul_sum, prod_q[31:1]};
    assign w_rem_sh   = {prod_q[63:32], prod_q[31]};
    assign w_ge       = (w_rem_sh >= {1'b0, b_q});
    assign w_diff     = w_rem_sh[31:0] - b_q;
    assign w_div_next = {(w_ge ? w_diff : w_rem_sh[31:0]), prod_q[30:0], w_ge};

    logic [63:0] w_prod_fix;
    logic [31:0] w_quo, w_rem, w_mul_res, w_div_res, w_fix_res;

    assign w_prod_fix = (sa_q ^ sb_q) ? -prod_q : prod_q;
    assign w_quo      = prod_q[31:0];
    assign w_rem      = prod_q[63:32];
    assign w_mul_res  = (op_q[1:0] == 2'b00) ? w_prod_fix[31:0] : w_prod_fix[63:32];

    // Divide-by-zero is patched here so the long path matches the early-out result
    always_comb begin
        w_div_res = 32'd0;
        if (b_q == 32'd0)
            w_div_res = op_q[1] ? (sa_q ? -a_q : a_q) : 32'hFFFF_FFFF;
        else if (op_q[1])
            w_div_res = sa_q ? -w_rem : w_rem;
        else
            w_div_res = (sa_q ^ sb_q) ? -w_quo : w_quo;
    end

    assign w_fix_res = op_q[2] ? w_div_res : w_mul_res;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        prod_d   = prod_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    op_d    = funct3;
                    a_d     = w_a_mag;
                    b_d     = w_b_mag;
                    sa_d    = w_sa;
                    sb_d    = w_sb;
                    cnt_d   = 5'd0;
                    prod_d  = funct3[2] ? {32'd0, w_a_mag} : {32'd0, w_b_mag};
                    state_d = S_RUN;
`ifdef MULDIV_EARLY_OUT_EN
                    if (w_early) begin
                        result_d = w_early_res;
                        state_d  = S_DONE;
                    end
`endif
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    prod_d = op_q[2] ? w_div_next : w_mul_next;
                    cnt_d  = cnt_q + 5'd1;
                    if (cnt_q == 5'd31)
                        state_d = S_FIXUP;
                end
            end
            S_FIXUP: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    result_d = w_fix_res;
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            op_q     <= 3'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            prod_q   <= 64'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            prod_q   <= prod_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign stall  = rst_n & ((start & (state_q == S_IDLE)) | (state_q == S_RUN) | (state_q == S_FIXUP));
    assign done   = (state_q == S_DONE) & ~flush;
    assign result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
// ============================================================================
// Module   : tb_muldiv_sequencer
// Purpose  : Scoreboard bench for muldiv_sequencer; directed RV32M vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] rs1 = 32'd0;
    logic [31:0] rs2 = 32'd0;
    logic        busy, stall, done;
    logic [31:0] result;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int EL = 1;
`else
    localparam int EL = 34;
`endif

    muldiv_sequencer dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .rs1    (rs1),
        .rs2    (rs2),
        .flush  (flush),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          at;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: pulse at cycle %0d result %h, expected no pulse", cyc, result);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_result"}, result, mon_e.res);
                chk({mon_e.name, "_cycle"}, cyc, mon_e.at);
            end
        end
    end

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: busy=%b after %0d cycles, expected 0", nm, busy, n);
        end
    endtask

    task automatic issue(input string nm, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expv, input int lat);
        exp_t e;
        wait_idle(nm);
        funct3 = f;
        rs1    = a;
        rs2    = b;
        start  = 1'b1;
        #1;
        chk({nm, "_stall_idle"}, {31'd0, stall}, 32'd1);
        chk({nm, "_busy_idle"}, {31'd0, busy}, 32'd0);
        e.res  = expv;
        e.at   = cyc + lat;
        e.name = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({nm, "_busy_run"}, {31'd0, busy}, 32'd1);
    endtask

    logic [31:0] prev;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", result, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        start = 1'b1;
        #1;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Multiply family
        issue("mul_7xm3",   3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
        issue("mulhu_max",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        issue("mulh_m1",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34);
        issue("mulhsu_m1",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
        issue("mul_shift",  3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 34);
        issue("mulh_min",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);

        // Divide family, including special cases
        issue("div_m20_6",  3'b100, 32'hFFFF_FFEC, 32'd6,         32'hFFFF_FFFD, 34);
        issue("rem_m20_6",  3'b110, 32'hFFFF_FFEC, 32'd6,         32'hFFFF_FFFE, 34);
        issue("div_20_m6",  3'b100, 32'd20,        32'hFFFF_FFFA, 32'hFFFF_FFFD, 34);
        issue("rem_20_m6",  3'b110, 32'd20,        32'hFFFF_FFFA, 32'h0000_0002, 34);
        issue("divu_100_7", 3'b101, 32'd100,       32'd7,         32'h0000_000E, 34);
        issue("remu_100_7", 3'b111, 32'd100,       32'd7,         32'h0000_0002, 34);
        issue("divu_dz",    3'b101, 32'h0000_1234, 32'd0,         32'hFFFF_FFFF, EL);
        issue("remu_dz",    3'b111, 32'h0000_1234, 32'd0,         32'h0000_1234, EL);
        issue("div_dz_neg", 3'b100, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, EL);
        issue("rem_dz_neg", 3'b110, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, EL);
        issue("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, EL);
        issue("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, EL);

        // Flush at counter 10 with an ignored start injected while busy
        wait_idle("flush");
        prev   = result;
        funct3 = 3'b100;
        rs1    = 32'd1000;
        rs2    = 32'd7;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        funct3 = 3'b101;
        rs1    = 32'd0;
        rs2    = 32'd0;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        flush = 1'b1;
        #1;
        chk("flush_stall_run", {31'd0, stall}, 32'd1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_result", result, prev);
        repeat (40) @(posedge clk);
        #1;
        chk("flush_busy_late", {31'd0, busy}, 32'd0);
        chk("flush_result_late", result, prev);

        // Flush and start together in IDLE: start is dropped
        funct3 = 3'b000;
        rs1    = 32'd3;
        rs2    = 32'd4;
        start  = 1'b1;
        flush  = 1'b1;
        #1;
        chk("fs_stall", {31'd0, stall}, 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        chk("fs_busy", {31'd0, busy}, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("fs_result", result, prev);
        issue("mul_after_flush", 3'b000, 32'd3, 32'd4, 32'h0000_000C, 34);

        // Reset during a divide
        wait_idle("rst_mid");
        funct3 = 3'b100;
        rs1    = 32'hFFFF_FFEC;
        rs2    = 32'd6;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        rst_n = 1'b0;
        start = 1'b1;
        #1;
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_done", {31'd0, done}, 32'd0);
        chk("rstmid_result", result, 32'd0);
        chk("rstmid_stall", {31'd0, stall}, 32'd0);
        #2;
        start = 1'b0;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("rstmid_busy_late", {31'd0, busy}, 32'd0);
        chk("rstmid_result_late", result, 32'd0);
        issue("div_after_rst", 3'b100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 34);
        issue("rem_after_rst", 3'b110, 32'd100, 32'hFFFF_FFF9, 32'h0000_0002, 34);

        wait_idle("drain");
        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request a new RV32M operation; sampled only in IDLE.
REQ-005 funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 rs1  input  32  operand A (multiplicand / dividend); sampled with start.
REQ-007 rs2  input  32  operand B (multiplier / divisor); sampled with start.
REQ-008 flush  input  1  abort any in-flight operation.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 stall  output  1  hold fetch/PC; combinational: (start & IDLE) | RUN | FIXUP.
REQ-011 done  output  1  one-cycle pulse; result valid in that cycle.
REQ-012 result  output  32  registered result, held until the next DONE.

Function
REQ-013 SHALL implement FSM IDLE -> RUN -> FIXUP -> DONE -> IDLE.
REQ-014 IDLE: start=1 latches funct3, rs1, rs2 and converts to magnitudes per signedness; clears 5-bit counter; next RUN.
REQ-015 RUN: one shift-add (mul) or restoring shift-subtract (div) step per cycle; counter 0..31; leave for FIXUP after the step with counter=31 (32 cycles).
REQ-016 Multiply SHALL use a 64-bit product; MUL returns [31:0]; MULH/MULHSU/MULHU return [63:32].
REQ-017 MULHSU: rs1 signed, rs2 unsigned; MULH both signed; MULHU both unsigned.
REQ-018 FIXUP: apply sign correction (negate product if operand signs differ; quotient sign = sA^sB; remainder sign = sA); next DONE.
REQ-019 DONE: result loads the final value, done=1 for exactly this cycle; next IDLE.
REQ-020 Latency: start accepted in cycle 0 -> done=1 in cycle 34.
REQ-021 Divide by zero: DIV/DIVU quotient = 0xFFFFFFFF; REM/REMU = rs1.
REQ-022 Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV = 0x80000000; REM = 0.
REQ-023 start while busy=1 SHALL be ignored; no queuing.
REQ-024 flush=1 in any non-IDLE state: next state IDLE, no done pulse, result unchanged.
REQ-025 flush and start in the same IDLE cycle: flush wins, start ignored, stall still follows REQ-010.
REQ-026 A new start is accepted in the IDLE cycle directly after DONE (back-to-back throughput 35 cycles).

Reset
REQ-027 rst_n=0 SHALL force IDLE immediately: busy=0, done=0, counter=0, result=0x00000000, operand registers=0.
REQ-028 Reset mid-operation discards the operation; no done pulse after reset release.
REQ-029 stall SHALL be 0 while rst_n=0, regardless of start.

Configuration
REQ-030 Macro MULDIV_EARLY_OUT_EN: when defined, divide by zero and signed overflow (REQ-021/022) in IDLE go directly to DONE with the special result; done in cycle 1.
REQ-031 Without MULDIV_EARLY_OUT_EN: these cases take the full RUN/FIXUP path with latency 34; the results are identical.
REQ-032 Multiply latency and results SHALL be unaffected by the macro.

Verification
REQ-033 MUL rs1=7, rs2=-3 (0xFFFFFFFD) -> done at cycle 34, result=0xFFFFFFEB; busy 1 for cycles 1..34.
REQ-034 MULHU rs1=rs2=0xFFFFFFFF -> result=0xFFFFFFFE; MULH same operands -> result=0x00000000.
REQ-035 DIV rs1=-20, rs2=6 -> result=0xFFFFFFFD; REM same operands -> result=0xFFFFFFFE.
REQ-036 DIVU rs2=0, rs1=0x1234 -> result=0xFFFFFFFF; REMU -> 0x00001234; done at cycle 1 with macro, cycle 34 without.
REQ-037 flush at RUN counter=10, then start re-asserted during busy -> no done pulse, returns IDLE, result unchanged; the ignored start produces no side effects.
REQ-038 rst_n low at cycle 20 of DIV -> immediate IDLE, result=0, no done pulse; next start completes normally in 34 cycles.
